// File: rtl/per_clk_pkg.sv
// Shared types for the per-peripheral kernel clock request controller:
// FSM state encodings, debug state width and a width helper.
package per_clk_pkg;

  localparam int REQ_STATE_W = 3;

  typedef enum logic [REQ_STATE_W-1:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    ACTIVE = 3'd2,
    HOLD   = 3'd3,
    ERR    = 3'd4
  } per_clk_state_e;

  // clog2 clamped to at least one bit so degenerate parameters still give legal vectors
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the i_clk domain.
module sync_2ff (
  input  logic i_clk,
  input  logic sys_rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge i_clk) begin
    if (sys_rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/per_ker_clk_req_ctrl.sv
// Kernel clock request FSM: requests the kernel clock on activity, holds it for an idle
// window, and optionally watches for a missing acknowledge (macro PER_KER_REQ_TIMEOUT_EN).
module per_ker_clk_req_ctrl
  import per_clk_pkg::*;
#(
  parameter int KER_CLK_SRC_NUM = 5,
  parameter int HOLD_CYCLES     = 16,
  parameter int ACK_TIMEOUT     = 256
) (
  input  logic                                   i_clk,
  input  logic                                   sys_rst,
  input  logic                                   d3_deepsleep,
  input  logic                                   wakeup_evt,
  input  logic                                   xfer_busy,
  input  logic                                   ker_clk_present,
  input  logic [clog2_min1(KER_CLK_SRC_NUM)-1:0] ker_clk_sel,
  output logic                                   per_ker_clk_req,
  output logic                                   ker_clk_rdy,
  output logic                                   req_timeout_err,
  output logic [REQ_STATE_W-1:0]                 req_state
);

  localparam int HOLD_W = clog2_min1(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  per_clk_state_e    state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              req_reg, req_next;
  logic              rdy_reg, rdy_next;
  logic              ack;

  sync_2ff u_sync_ack (
    .i_clk   (i_clk),
    .sys_rst (sys_rst),
    .d       (ker_clk_present),
    .q       (ack)
  );

  // The request is already low in IDLE, so deep sleep does not alter behaviour, and the
  // source select is deliberately not re-handshaked while the request is up.
  logic unused_inputs;
  assign unused_inputs = ^{d3_deepsleep, ker_clk_sel};

`ifdef PER_KER_REQ_TIMEOUT_EN
  localparam int WD_W = clog2_min1(ACK_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic            err_reg, err_next;
`else
  logic unused_cfg;
  assign unused_cfg = ^ACK_TIMEOUT;
`endif

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = '0;
`ifdef PER_KER_REQ_TIMEOUT_EN
    wd_cnt_next   = '0;
    err_next      = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (wakeup_evt || xfer_busy) state_next = REQ;
      end
      REQ: begin
        if (ack) begin
          state_next = ACTIVE;
        end
`ifdef PER_KER_REQ_TIMEOUT_EN
        else if (wd_cnt_reg == WD_LAST) begin
          state_next = ERR;
          err_next   = 1'b1;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
`endif
      end
      ACTIVE: begin
        if (!ack) begin
          state_next = REQ;
        end else if (!xfer_busy && !wakeup_evt) begin
          state_next    = HOLD;
          hold_cnt_next = HOLD_LOAD;
        end
      end
      HOLD: begin
        // Clock loss outranks everything; activity outranks expiry of the hold window.
        if (!ack) begin
          state_next = REQ;
        end else if (wakeup_evt || xfer_busy) begin
          state_next = ACTIVE;
        end else if (hold_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      ERR: begin
        if (wakeup_evt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    req_next = (state_next == REQ) || (state_next == ACTIVE) || (state_next == HOLD);
    rdy_next = (state_next == ACTIVE) || (state_next == HOLD);
  end

  always_ff @(posedge i_clk) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      req_reg      <= 1'b0;
      rdy_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      req_reg      <= req_next;
      rdy_reg      <= rdy_next;
    end
  end

`ifdef PER_KER_REQ_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (sys_rst) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
      err_reg    <= err_next;
    end
  end

  assign req_timeout_err = err_reg;
`else
  assign req_timeout_err = 1'b0;
`endif

  assign per_ker_clk_req = req_reg;
  assign ker_clk_rdy     = rdy_reg;
  assign req_state       = state_reg;

endmodule

// File: tb/tb_per_ker_clk_req_ctrl.sv
// Directed bench for per_ker_clk_req_ctrl (HOLD_CYCLES=16, ACK_TIMEOUT=8); the timeout
// scenario follows PER_KER_REQ_TIMEOUT_EN.
module tb_per_ker_clk_req_ctrl;
  import per_clk_pkg::*;

  logic       i_clk = 1'b0;
  logic       sys_rst;
  logic       d3_deepsleep;
  logic       wakeup_evt;
  logic       xfer_busy;
  logic       ker_clk_present;
  logic [2:0] ker_clk_sel;
  logic       per_ker_clk_req;
  logic       ker_clk_rdy;
  logic       req_timeout_err;
  logic [2:0] req_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int drops;

  always #5 i_clk = ~i_clk;

  per_ker_clk_req_ctrl #(
    .KER_CLK_SRC_NUM (5),
    .HOLD_CYCLES     (16),
    .ACK_TIMEOUT     (8)
  ) dut (
    .i_clk           (i_clk),
    .sys_rst         (sys_rst),
    .d3_deepsleep    (d3_deepsleep),
    .wakeup_evt      (wakeup_evt),
    .xfer_busy       (xfer_busy),
    .ker_clk_present (ker_clk_present),
    .ker_clk_sel     (ker_clk_sel),
    .per_ker_clk_req (per_ker_clk_req),
    .ker_clk_rdy     (ker_clk_rdy),
    .req_timeout_err (req_timeout_err),
    .req_state       (req_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, act);
    end
  endtask

  task automatic check_outs(input string tag, input logic req, input logic rdy,
                            input logic err, input logic [2:0] st);
    check({tag, "_req"},   32'(per_ker_clk_req), 32'(req));
    check({tag, "_rdy"},   32'(ker_clk_rdy),     32'(rdy));
    check({tag, "_err"},   32'(req_timeout_err), 32'(err));
    check({tag, "_state"}, 32'(req_state),       32'(st));
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic tick_count_drops(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (!per_ker_clk_req) drops++;
    end
  endtask

  initial begin
    sys_rst = 1'b1; d3_deepsleep = 1'b0; wakeup_evt = 1'b0; xfer_busy = 1'b0;
    ker_clk_present = 1'b0; ker_clk_sel = 3'd0;
    tick(3);
    check_outs("reset", 1'b0, 1'b0, 1'b0, IDLE);
    sys_rst = 1'b0;
    tick(1);

    // Basic handshake: label this cycle 10.
    wakeup_evt = 1'b1;
    tick(1);                                  // cycle 11
    wakeup_evt = 1'b0;
    check_outs("hs_c11", 1'b1, 1'b0, 1'b0, REQ);
    tick(3);                                  // cycle 14
    ker_clk_present = 1'b1;
    tick(2);                                  // cycle 16
    check("hs_c16_rdy", 32'(ker_clk_rdy), 32'd0);
    xfer_busy = 1'b1;
    tick(1);                                  // cycle 17
    check_outs("hs_c17", 1'b1, 1'b1, 1'b0, ACTIVE);
    ker_clk_sel = 3'd4;                       // select change while requested: no effect

    // Hold expiry.
    tick(33);                                 // cycle 50
    check("hold_c50_state", 32'(req_state), 32'(ACTIVE));
    xfer_busy = 1'b0;
    tick(1);                                  // cycle 51
    check_outs("hold_c51", 1'b1, 1'b1, 1'b0, HOLD);
    tick(15);                                 // cycle 66
    check_outs("hold_c66", 1'b1, 1'b1, 1'b0, HOLD);
    tick(1);                                  // cycle 67
    check_outs("hold_c67", 1'b0, 1'b0, 1'b0, IDLE);

    d3_deepsleep = 1'b1;
    tick(2);
    check_outs("deepsleep_idle", 1'b0, 1'b0, 1'b0, IDLE);
    d3_deepsleep = 1'b0;

    // Hold reactivation, including on the counter==0 cycle. Label this cycle A.
    wakeup_evt = 1'b1;
    tick(1);                                  // A+1 REQ (ack already up)
    wakeup_evt = 1'b0;
    tick(1);                                  // A+2
    check("react_active", 32'(req_state), 32'(ACTIVE));
    tick(1);                                  // A+3 HOLD, counter 15
    check("react_hold1", 32'(req_state), 32'(HOLD));
    drops = 0;
    tick_count_drops(5);                      // A+8, counter 10
    wakeup_evt = 1'b1;
    tick(1);                                  // A+9
    wakeup_evt = 1'b0;
    if (!per_ker_clk_req) drops++;
    check("react_mid_state", 32'(req_state), 32'(ACTIVE));
    tick(1);                                  // A+10 HOLD, counter 15
    if (!per_ker_clk_req) drops++;
    check("react_hold2", 32'(req_state), 32'(HOLD));
    tick_count_drops(15);                     // A+25, counter 0
    check("react_cnt0_state", 32'(req_state), 32'(HOLD));
    wakeup_evt = 1'b1;
    tick(1);                                  // A+26
    wakeup_evt = 1'b0;
    if (!per_ker_clk_req) drops++;
    check_outs("react_cnt0_win", 1'b1, 1'b1, 1'b0, ACTIVE);
    check("react_req_drops", 32'(drops), 32'd0);
    xfer_busy = 1'b1;

    // Clock loss during ACTIVE. Label cycle B.
    tick(2);
    ker_clk_present = 1'b0;
    tick(2);                                  // B+2
    check_outs("loss_b2", 1'b1, 1'b1, 1'b0, ACTIVE);
    tick(1);                                  // B+3
    check_outs("loss_b3", 1'b1, 1'b0, 1'b0, REQ);
    ker_clk_present = 1'b1;
    tick(3);
    check_outs("loss_recover", 1'b1, 1'b1, 1'b0, ACTIVE);
    xfer_busy = 1'b0;
    tick(18);
    check_outs("loss_to_idle", 1'b0, 1'b0, 1'b0, IDLE);
    ker_clk_present = 1'b0;
    tick(3);

    // Acknowledge never arrives. Label cycle C.
    wakeup_evt = 1'b1;
    tick(1);                                  // C+1
    wakeup_evt = 1'b0;
    check_outs("to_c1", 1'b1, 1'b0, 1'b0, REQ);
`ifdef PER_KER_REQ_TIMEOUT_EN
    tick(7);                                  // C+8, eighth cycle in REQ
    check_outs("to_c8", 1'b1, 1'b0, 1'b0, REQ);
    tick(1);                                  // C+9
    check_outs("to_c9", 1'b0, 1'b0, 1'b1, ERR);
    tick(2);
    check_outs("to_err_hold", 1'b0, 1'b0, 1'b1, ERR);
    wakeup_evt = 1'b1;
    tick(1);
    wakeup_evt = 1'b0;
    check_outs("to_err_exit", 1'b0, 1'b0, 1'b1, IDLE);
    wakeup_evt = 1'b1;
    tick(1);
    wakeup_evt = 1'b0;
    check_outs("to_rereq", 1'b1, 1'b0, 1'b1, REQ);
`else
    drops = 0;
    tick_count_drops(1000);
    check("nto_req_drops", 32'(drops), 32'd0);
    check_outs("nto_after1000", 1'b1, 1'b0, 1'b0, REQ);
`endif

    // Reset mid-REQ.
    tick(2);
    check("rst_pre_state", 32'(req_state), 32'(REQ));
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    check_outs("rst_mid", 1'b0, 1'b0, 1'b0, IDLE);
    tick(1);
    check_outs("rst_after", 1'b0, 1'b0, 1'b0, IDLE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/per_ker_clk_req_ctrl.md
PER_KER_CLK_REQ_CTRL -- requirements
Module: per_ker_clk_req_ctrl

Interface
REQ-001 Parameter KER_CLK_SRC_NUM, default 5: number of selectable kernel clock sources.
REQ-002 Parameter HOLD_CYCLES, default 16: idle cycles the request is held after activity ends; legal range 1..65535.
REQ-003 Parameter ACK_TIMEOUT, default 256: cycles allowed from request to clock-present; legal range 1..65535.
REQ-004 Port i_clk  in  1: always-on clock; every flop is clocked by it; it is never gated by this block.
REQ-005 Port sys_rst  in  1: reset, synchronous to i_clk, active-high.
REQ-006 Port d3_deepsleep  in  1: domain is in deep sleep, so a kernel clock is only supplied on request.
REQ-007 Port wakeup_evt  in  1: single-cycle pulse for peripheral activity start, such as a start bit or address match.
REQ-008 Port xfer_busy  in  1: peripheral transfer in progress; level signal.
REQ-009 Port ker_clk_present  in  1: asynchronous level signal from the kernel-clock domain, high while the kernel clock runs.
REQ-010 Port ker_clk_sel  in  max(clog2(KER_CLK_SRC_NUM),1): kernel clock source select; static while the request is high.
REQ-011 Port per_ker_clk_req  out  1: kernel clock request to the RCC per-peripheral clock/reset control.
REQ-012 Port ker_clk_rdy  out  1: the kernel clock is confirmed running; the peripheral may use it.
REQ-013 Port req_timeout_err  out  1: sticky error flag for an acknowledge timeout.
REQ-014 Port req_state  out  3: current FSM state encoding, for debug.

Function
REQ-015 ker_clk_present SHALL pass through a 2-flop synchronizer; "ack" below means the synchronized value, so acknowledge latency is 2 cycles.
REQ-016 The FSM SHALL have the states IDLE, REQ, ACTIVE, HOLD and ERR, with registered outputs.
REQ-017 In IDLE, when wakeup_evt=1 or xfer_busy=1, the FSM SHALL go to REQ, with per_ker_clk_req=1 from the next cycle.
REQ-018 In IDLE with d3_deepsleep=0, per_ker_clk_req SHALL stay 0, because the RCC supplies the clock through the enables.
- Activity in this condition still moves the FSM to REQ.
- The request is asserted in REQ regardless of d3_deepsleep.
REQ-019 In REQ, when ack=1, the FSM SHALL go to ACTIVE and assert ker_clk_rdy in the same registered update.
REQ-020 In ACTIVE, when xfer_busy=0 and wakeup_evt=0, the FSM SHALL go to HOLD and load the hold counter with HOLD_CYCLES-1.
REQ-021 In HOLD, the counter SHALL decrement each cycle.
- When wakeup_evt=1 or xfer_busy=1, the FSM SHALL return to ACTIVE with no re-request, and the counter is discarded.
- When the counter reaches 0, the FSM SHALL go to IDLE and deassert per_ker_clk_req and ker_clk_rdy together.
REQ-022 If wakeup_evt and counter==0 occur in the same cycle, activity SHALL win and the FSM goes to ACTIVE.
REQ-023 In ACTIVE or HOLD, if ack falls to 0, the FSM SHALL go to REQ and deassert ker_clk_rdy next cycle; per_ker_clk_req stays 1.
REQ-024 per_ker_clk_req SHALL be 1 in REQ, ACTIVE and HOLD, and 0 in IDLE and ERR.
REQ-025 A change of ker_clk_sel while per_ker_clk_req=1 SHALL be ignored functionally; there is no re-handshake.
REQ-026 Counter widths SHALL be clog2 of the parameter value; counters SHALL saturate and never wrap.

Reset
REQ-027 While sys_rst=1, at every rising edge of i_clk, the block SHALL reset to the following values:
- state IDLE;
- per_ker_clk_req=0, ker_clk_rdy=0, req_timeout_err=0, req_state=IDLE;
- counters 0 and synchronizer flops 0.
REQ-028 Reset asserted mid-handshake SHALL drop per_ker_clk_req on the cycle following the reset edge, with no pending state retained.

Configuration
REQ-029 With PER_KER_REQ_TIMEOUT_EN defined, the ack timeout watchdog SHALL be built in:
- the watchdog counts cycles in REQ;
- on reaching ACK_TIMEOUT it moves to ERR, sets req_timeout_err and drops the request;
- ERR returns to IDLE on the next cycle in which wakeup_evt=1, while req_timeout_err stays 1 until sys_rst.
REQ-030 Without PER_KER_REQ_TIMEOUT_EN, REQ SHALL wait for ack indefinitely, ERR SHALL be unreachable, and req_timeout_err SHALL be tied to 0.

Structure
REQ-031 The shared package per_clk_pkg SHALL hold the FSM state typedef and encodings (IDLE=0, REQ=1, ACTIVE=2, HOLD=3, ERR=4) and the req_state width constant.
REQ-032 The synchronizer SHALL be one sub-module, sync_2ff, instantiated once for ker_clk_present.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Basic handshake: wakeup_evt pulse at cycle 10, with ker_clk_present raised at cycle 14 -> req=1 at cycle 11, ker_clk_rdy=1 at cycle 17.
- Hold expiry (HOLD_CYCLES=16): xfer_busy drops at cycle 50 -> HOLD for 16 cycles, then req=0 and rdy=0 together at cycle 67.
- Hold reactivation: wakeup_evt pulse in HOLD, including on the counter==0 cycle -> ACTIVE, req never drops.
- Clock loss: ker_clk_present falls during ACTIVE -> rdy=0 after 3 cycles, state REQ, req=1.
- Timeout (macro on, ACK_TIMEOUT=8): no ack -> ERR after 8 cycles in REQ, req=0 and err=1. Macro off: req held 1000 cycles, err=0.
- Reset mid-REQ: sys_rst asserted for 1 cycle -> every output matches REQ-027 on the next cycle.
